// File: rtl/synth_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : synth_frame_sequencer
// Purpose  : Upstream controller for the additive Synth stage. Holds a
//            host-written partial table. On start it clears Synth, loads the
//            partials, sweeps x = 0..FRAME_LEN-1 under a credit limit, and
//            buffers Synth results in a fall-through FIFO for downstream.
// Ports    : clk, rst (async, active-high)
//            tbl_we/tbl_addr/tbl_mag/tbl_freq/tbl_phase : table write (IDLE only)
//            num_partials, start                         : frame request
//            busy, done                                  : frame status
//            syn_clr, syn_wr_en, syn_magnitude/frequency/phase, syn_x : to Synth
//            syn_out                                     : from Synth
//            smp_data, smp_valid, smp_ready              : sample stream
// Options  : `define SYNTH_SEQ_LOOP_EN for continuous looping sweeps; a start
//            pulse during SWEEP then ends the loop after the current frame.
// Revision : 1.0 - initial release
// ============================================================================
module synth_frame_sequencer #(
  parameter int NUM_PARTIALS = 16,
  parameter int FRAME_LEN    = 2048,
  parameter int SYNTH_LAT    = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tbl_we,
  input  logic [$clog2(NUM_PARTIALS)-1:0] tbl_addr,
  input  logic [15:0]                     tbl_mag,
  input  logic [10:0]                     tbl_freq,
  input  logic [15:0]                     tbl_phase,
  input  logic [$clog2(NUM_PARTIALS):0]   num_partials,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            syn_clr,
  output logic                            syn_wr_en,
  output logic [15:0]                     syn_magnitude,
  output logic [10:0]                     syn_frequency,
  output logic [15:0]                     syn_phase,
  output logic [10:0]                     syn_x,
  input  logic [15:0]                     syn_out,
  output logic [15:0]                     smp_data,
  output logic                            smp_valid,
  input  logic                            smp_ready
);

  localparam int c_AW = $clog2(NUM_PARTIALS);
  localparam int c_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CW = $clog2(FIFO_DEPTH + SYNTH_LAT + 1) + 1;

  localparam logic [c_AW:0]   c_NP_MAX = (c_AW+1)'(NUM_PARTIALS);
  localparam logic [10:0]     c_X_LAST = 11'(FRAME_LEN - 1);
  localparam logic [c_CW-1:0] c_DEPTH  = c_CW'(FIFO_DEPTH);
  localparam logic [c_PW-1:0] c_P_LAST = c_PW'(FIFO_DEPTH - 1);

  localparam logic [2:0] c_S_IDLE  = 3'd0;
  localparam logic [2:0] c_S_CLEAR = 3'd1;
  localparam logic [2:0] c_S_LOAD  = 3'd2;
  localparam logic [2:0] c_S_SWEEP = 3'd3;
  localparam logic [2:0] c_S_DRAIN = 3'd4;
  localparam logic [2:0] c_S_DONE  = 3'd5;

  logic [2:0]           r_state;
  logic [c_AW:0]        r_count;
  logic [c_AW-1:0]      r_idx;
  logic [10:0]          r_x;
  logic [15:0]          r_hold_mag;
  logic [10:0]          r_hold_freq;
  logic [15:0]          r_hold_phase;
  logic [SYNTH_LAT-1:0] r_pipe;
  logic [c_CW-1:0]      r_fcnt;
  logic [c_PW-1:0]      r_wp;
  logic [c_PW-1:0]      r_rp;
`ifdef SYNTH_SEQ_LOOP_EN
  logic                 r_stop_req;
`endif

  // Partial table and FIFO storage carry no reset.
  logic [15:0] r_tbl_mag   [NUM_PARTIALS];
  logic [10:0] r_tbl_freq  [NUM_PARTIALS];
  logic [15:0] r_tbl_phase [NUM_PARTIALS];
  logic [15:0] r_fifo      [FIFO_DEPTH];

  logic [c_CW-1:0] w_inflight;
  logic            w_issue;
  logic            w_x_last;
  logic            w_push;
  logic            w_pop;
  logic [c_AW:0]   w_np_sat;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < SYNTH_LAT; i++) begin
      w_inflight = w_inflight + c_CW'(r_pipe[i]);
    end
  end

  // A credit covers both samples still inside Synth and samples parked in the
  // FIFO, so a tag leaving the pipe always finds a free FIFO slot.
  assign w_issue  = (r_state == c_S_SWEEP) && ((w_inflight + r_fcnt) < c_DEPTH);
  assign w_x_last = (r_x == c_X_LAST);
  assign w_push   = r_pipe[SYNTH_LAT-1];
  assign w_pop    = (r_fcnt != '0) && smp_ready;
  assign w_np_sat = (num_partials > c_NP_MAX) ? c_NP_MAX : num_partials;

  always_ff @(posedge clk) begin
    if (tbl_we && (r_state == c_S_IDLE)) begin
      r_tbl_mag[tbl_addr]   <= tbl_mag;
      r_tbl_freq[tbl_addr]  <= tbl_freq;
      r_tbl_phase[tbl_addr] <= tbl_phase;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_S_IDLE;
      r_count      <= '0;
      r_idx        <= '0;
      r_x          <= '0;
      r_hold_mag   <= '0;
      r_hold_freq  <= '0;
      r_hold_phase <= '0;
`ifdef SYNTH_SEQ_LOOP_EN
      r_stop_req   <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (start) begin
            r_count <= w_np_sat;
            r_x     <= '0;
            r_state <= c_S_CLEAR;
`ifdef SYNTH_SEQ_LOOP_EN
            r_stop_req <= 1'b0;
`endif
          end
        end
        c_S_CLEAR: begin
          r_idx   <= '0;
          r_state <= (r_count != '0) ? c_S_LOAD : c_S_SWEEP;
        end
        c_S_LOAD: begin
          r_hold_mag   <= r_tbl_mag[r_idx];
          r_hold_freq  <= r_tbl_freq[r_idx];
          r_hold_phase <= r_tbl_phase[r_idx];
          r_idx        <= r_idx + 1'b1;
          if ({1'b0, r_idx} == (r_count - 1'b1)) begin
            r_state <= c_S_SWEEP;
          end
        end
        c_S_SWEEP: begin
`ifdef SYNTH_SEQ_LOOP_EN
          if (start) begin
            r_stop_req <= 1'b1;
          end
`endif
          if (w_issue) begin
            // Wrapping here leaves x at 0 for the next frame or loop pass.
            r_x <= w_x_last ? 11'd0 : r_x + 11'd1;
            if (w_x_last) begin
`ifdef SYNTH_SEQ_LOOP_EN
              if (r_stop_req || start) begin
                r_state <= c_S_DRAIN;
              end
`else
              r_state <= c_S_DRAIN;
`endif
            end
          end
        end
        c_S_DRAIN: begin
          if ((w_inflight == '0) && (r_fcnt == '0)) begin
            r_state <= c_S_DONE;
          end
        end
        c_S_DONE: begin
          r_state <= c_S_IDLE;
        end
        default: begin
          r_state <= c_S_IDLE;
        end
      endcase
    end
  end

  // Issue tags travel alongside Synth's latency; the oldest tag marks syn_out.
  generate
    if (SYNTH_LAT == 1) begin : g_pipe_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pipe <= '0;
        else     r_pipe <= w_issue;
      end
    end else begin : g_pipe_shift
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pipe <= '0;
        else     r_pipe <= {r_pipe[SYNTH_LAT-2:0], w_issue};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wp] <= syn_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fcnt <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
    end else begin
      if (w_push) r_wp <= (r_wp == c_P_LAST) ? '0 : r_wp + 1'b1;
      if (w_pop)  r_rp <= (r_rp == c_P_LAST) ? '0 : r_rp + 1'b1;
      if (w_push && !w_pop)      r_fcnt <= r_fcnt + 1'b1;
      else if (!w_push && w_pop) r_fcnt <= r_fcnt - 1'b1;
    end
  end

  assign busy          = (r_state != c_S_IDLE) && (r_state != c_S_DONE);
`ifdef SYNTH_SEQ_LOOP_EN
  assign done          = (r_state == c_S_DONE) ||
                         (w_issue && w_x_last && !r_stop_req && !start);
`else
  assign done          = (r_state == c_S_DONE);
`endif
  assign syn_clr       = (r_state == c_S_CLEAR);
  assign syn_wr_en     = (r_state == c_S_LOAD);
  assign syn_magnitude = syn_wr_en ? r_tbl_mag[r_idx]   : r_hold_mag;
  assign syn_frequency = syn_wr_en ? r_tbl_freq[r_idx]  : r_hold_freq;
  assign syn_phase     = syn_wr_en ? r_tbl_phase[r_idx] : r_hold_phase;
  assign syn_x         = r_x;
  assign smp_valid     = (r_fcnt != '0);
  assign smp_data      = smp_valid ? r_fifo[r_rp] : 16'd0;

endmodule
`default_nettype wire

// File: tb/tb_synth_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_synth_frame_sequencer
// Purpose  : Self-checking bench for synth_frame_sequencer with a behavioural
//            Synth stand-in (fixed 2-cycle latency, sample = f(x)).
// Revision : 1.0 - initial release
// ============================================================================
module tb_synth_frame_sequencer;

  localparam int NP = 16;
  localparam int FL = 8;
  localparam int SL = 2;
  localparam int FD = 4;

  logic        clk, rst;
  logic        tbl_we;
  logic [3:0]  tbl_addr;
  logic [15:0] tbl_mag;
  logic [10:0] tbl_freq;
  logic [15:0] tbl_phase;
  logic [4:0]  num_partials;
  logic        start;
  logic        busy, done, syn_clr, syn_wr_en;
  logic [15:0] syn_magnitude;
  logic [10:0] syn_frequency;
  logic [15:0] syn_phase;
  logic [10:0] syn_x;
  logic [15:0] syn_out;
  logic [15:0] smp_data;
  logic        smp_valid, smp_ready;

  synth_frame_sequencer #(
    .NUM_PARTIALS(NP), .FRAME_LEN(FL), .SYNTH_LAT(SL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_mag(tbl_mag),
    .tbl_freq(tbl_freq), .tbl_phase(tbl_phase),
    .num_partials(num_partials), .start(start),
    .busy(busy), .done(done), .syn_clr(syn_clr), .syn_wr_en(syn_wr_en),
    .syn_magnitude(syn_magnitude), .syn_frequency(syn_frequency),
    .syn_phase(syn_phase), .syn_x(syn_x), .syn_out(syn_out),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synth stand-in: the result for x appears two clocks after x is presented.
  function automatic logic [15:0] fsamp(input int x);
    return 16'(32'h1234 + x * 97);
  endfunction

  logic [10:0] x_d1, x_d2;
  always @(posedge clk) begin
    x_d1 <= syn_x;
    x_d2 <= x_d1;
  end
  assign syn_out = fsamp(int'(x_d2));

  // Reference partial table as the host wrote it.
  logic [15:0] m_mag   [NP];
  logic [10:0] m_freq  [NP];
  logic [15:0] m_phase [NP];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic write_tbl(input int addr, input logic [15:0] mag,
                           input logic [10:0] freq, input logic [15:0] ph);
    tbl_we = 1'b1; tbl_addr = 4'(addr);
    tbl_mag = mag; tbl_freq = freq; tbl_phase = ph;
    @(negedge clk);
    tbl_we = 1'b0;
    m_mag[addr] = mag; m_freq[addr] = freq; m_phase[addr] = ph;
  endtask

  // One whole frame. ready_mode 1 = always ready, 0 = random. poke drives
  // start and a table write to entry 0 while the frame is busy.
  task automatic run_frame(input int np, input int exp_loads,
                           input int ready_mode, input bit poke);
    int cyc = 0, clr_cnt = 0, wr_cnt = 0, smp_cnt = 0;
    int clr_cyc = -1, first_wr = -1, last_valid = -1, done_cyc = -1;
    bit fin = 0;
    num_partials = 5'(np);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    while (!fin && cyc < 400) begin
      smp_ready = (ready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      if (poke && (cyc == 2 || cyc == 9)) begin
        start = 1'b1; tbl_we = 1'b1; tbl_addr = 4'd0;
        tbl_mag = 16'hDEAD; tbl_freq = 11'h7FF; tbl_phase = 16'hBEEF;
      end else begin
        start = 1'b0; tbl_we = 1'b0;
      end
      if (syn_clr) begin clr_cnt++; clr_cyc = cyc; end
      if (syn_wr_en) begin
        if (first_wr < 0) first_wr = cyc;
        if (wr_cnt < NP) begin
          check("load_mag",   32'(syn_magnitude), 32'(m_mag[wr_cnt]));
          check("load_freq",  32'(syn_frequency), 32'(m_freq[wr_cnt]));
          check("load_phase", 32'(syn_phase),     32'(m_phase[wr_cnt]));
        end
        wr_cnt++;
      end
      if (smp_valid) begin
        last_valid = cyc;
        if (smp_ready) begin
          check("sample_data", 32'(smp_data), 32'(fsamp(smp_cnt)));
          smp_cnt++;
        end
      end
      if (done) begin
        done_cyc = cyc;
        check("busy_low_at_done", 32'(busy), 32'd0);
        fin = 1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; tbl_we = 1'b0;
    check("frame_completed", 32'(fin), 32'd1);
    check("clr_count", 32'(clr_cnt), 32'd1);
    check("clr_first_cycle", 32'(clr_cyc), 32'd0);
    check("load_count", 32'(wr_cnt), 32'(exp_loads));
    if (exp_loads > 0) check("load_after_clr", 32'(first_wr), 32'(clr_cyc + 1));
    check("sample_count", 32'(smp_cnt), 32'(FL));
    check("done_after_empty", 32'(done_cyc - last_valid), 32'd2);
    check("done_single_pulse", 32'(done), 32'd0);
    check("idle_not_busy", 32'(busy), 32'd0);
  endtask

  typedef struct {
    int np;
    int exp_loads;
    int ready_mode;
    bit poke;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int dcnt;
    vecs[0] = '{0,  0,  1, 1'b0};
    vecs[1] = '{3,  3,  0, 1'b0};
    vecs[2] = '{16, 16, 0, 1'b0};
    vecs[3] = '{20, 16, 0, 1'b0};
    vecs[4] = '{31, 16, 1, 1'b0};
    vecs[5] = '{5,  5,  0, 1'b1};

    rst = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_mag = '0; tbl_freq = '0;
    tbl_phase = '0; num_partials = '0; start = 1'b0; smp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_done",      32'(done),          32'd0);
    check("rst_clr",       32'(syn_clr),       32'd0);
    check("rst_wr_en",     32'(syn_wr_en),     32'd0);
    check("rst_mag",       32'(syn_magnitude), 32'd0);
    check("rst_freq",      32'(syn_frequency), 32'd0);
    check("rst_phase",     32'(syn_phase),     32'd0);
    check("rst_x",         32'(syn_x),         32'd0);
    check("rst_smp_valid", 32'(smp_valid),     32'd0);
    check("rst_smp_data",  32'(smp_data),      32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two-partial frame with fixed table values.
    write_tbl(0, 16'h0100, 11'd1, 16'h0000);
    write_tbl(1, 16'h0080, 11'd3, 16'h4000);
    run_frame(2, 2, 1, 1'b0);
    check("hold_mag",   32'(syn_magnitude), 32'h0080);
    check("hold_freq",  32'(syn_frequency), 32'd3);
    check("hold_phase", 32'(syn_phase),     32'h4000);

    // Table-driven frames over random table contents and random readiness.
    for (int v = 0; v < 6; v++) begin
      for (int a = 0; a < NP; a++) begin
        write_tbl(a, 16'($urandom), 11'($urandom), 16'($urandom));
      end
      run_frame(vecs[v].np, vecs[v].exp_loads, vecs[v].ready_mode, vecs[v].poke);
    end
    // Entry 0 must have survived the writes attempted while busy.
    run_frame(1, 1, 1, 1'b0);

    // Backpressure: credit stops issue once four samples are outstanding.
    smp_ready = 1'b0;
    num_partials = 5'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    check("stall_x",         32'(syn_x),     32'd4);
    check("stall_valid",     32'(smp_valid), 32'd1);
    check("stall_head",      32'(smp_data),  32'(fsamp(0)));
    check("stall_busy",      32'(busy),      32'd1);
    k = 0;
    dcnt = 0;
    smp_ready = 1'b1;
    for (int c = 0; c < 200 && dcnt == 0; c++) begin
      if (smp_valid) begin
        check("stall_release_data", 32'(smp_data), 32'(fsamp(k)));
        k++;
      end
      if (done) dcnt++;
      @(negedge clk);
    end
    check("stall_release_count", 32'(k), 32'(FL));
    check("stall_release_done",  32'(dcnt), 32'd1);

    // Abort mid-sweep.
    num_partials = 5'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (syn_x != 11'd5 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("abort_reached_x5", 32'(syn_x), 32'd5);
    rst = 1'b1;
    #1;
    check("abort_busy",  32'(busy),      32'd0);
    check("abort_valid", 32'(smp_valid), 32'd0);
    check("abort_x",     32'(syn_x),     32'd0);
    check("abort_data",  32'(smp_data),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (done || smp_valid) dcnt++;
      @(negedge clk);
    end
    check("abort_quiet", 32'(dcnt), 32'd0);
    run_frame(0, 0, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
